ymux_rr: RTL and testbench
==========================

YMUX_RR -- requirements
Module: ymux_rr

Interface
REQ-001 Parameter W, default 2: data width per channel in bits; legal range 1..32.
REQ-002 Parameter N, default 4: input channel count; legal range 2..8.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_data, input, N*W: channel i data occupies bits [i*W+W-1 : i*W].
REQ-006 Port in_valid, input, N: channel i offers a word.
REQ-007 Port in_ready, output, N: channel i word is accepted this cycle.
REQ-008 Port out_data, output, W: registered output word.
REQ-009 Port out_valid, output, 1: out_data holds an unconsumed word.
REQ-010 Port out_ready, input, 1: the downstream consumer takes the word this cycle.
REQ-011 Port out_chan, output, clog2(N): source channel of out_data; registered.

Function
REQ-012 A transfer on side X occurs when X valid and X ready are both 1 on the same rising clk.
REQ-013 Output register state: EMPTY when out_valid=0, FULL when out_valid=1.
REQ-014 can_load = !out_valid | out_ready, combinational.
REQ-015 Grant: the first channel with in_valid=1, searching ptr+1, ptr+2, ... modulo N.
REQ-016 in_ready[i] = can_load & grant[i]; at most one bit is set; the rule is combinational, with no dependence on in_valid of the same channel beyond the grant.
REQ-017 On an input transfer: out_data <= granted word, out_chan <= i, out_valid <= 1, ptr <= i; latency is 1 cycle.
REQ-018 On an output transfer with no input transfer: out_valid <= 0; out_data and out_chan hold.
REQ-019 A simultaneous output and input transfer gives back-to-back streaming at 1 word per cycle with no bubble.
REQ-020 FULL and out_ready=0: out_data, out_chan, out_valid and ptr are frozen, and all in_ready are 0.
REQ-021 No in_valid set: ptr is unchanged and no grant is made.
REQ-022 The round-robin is fair: a continuously valid channel waits at most N-1 transfers.
REQ-023 ptr wraps from N-1 to 0; the search order also wraps.
REQ-024 Inputs need not hold after an in_valid deassertion; the block makes no stability assumption on unaccepted inputs.

Reset
REQ-025 While reset=1: out_valid=0, out_data=0, out_chan=0, ptr=N-1 (channel 0 has first priority), and in_ready=0.
REQ-026 A reset during FULL discards the held word; the first clock after release behaves as EMPTY.

Configuration
REQ-027 Macro YMUX_XFER_CNT_EN, when defined, adds output port xfer_cnt, 16 bits, a count of output transfers.
REQ-028 xfer_cnt resets to 0, increments by 1 per output transfer, and saturates at 16'hFFFF.
REQ-029 Without YMUX_XFER_CNT_EN, the port and the counter are absent, and all other behaviour is identical.

Structure
REQ-030 Package ymux_pkg holds the default W and N, the max-N constant 8, the counter width 16, and the EMPTY/FULL state encoding.
REQ-031 Sub-module ymux_rr_arb is combinational: inputs in_valid and ptr, output one-hot grant.
REQ-032 ymux_rr holds the output register, ptr and the optional counter.

Verification
REQ-033 Reset: assert reset for 2 cycles -> out_valid=0, out_data=0, ptr=N-1 (3 for N=4), in_ready=0000.
REQ-034 Single channel: W=2, N=4, ch2 valid with data 2'b11, out_ready=1 -> in_ready=0100; the next cycle out_data=3, out_chan=2, out_valid=1.
REQ-035 Fairness: all 4 channels valid, data=channel index, out_ready=1 -> out_chan sequence is 0,1,2,3,0, with no idle cycles.
REQ-036 Backpressure: FULL with out_chan=1, out_ready=0 for 3 cycles -> the output is stable, in_ready=0000, and ptr=1; on release, the next grant is 2.
REQ-037 Wrap and reset mid-operation: ptr=3 with only ch0 valid -> grant ch0; reset asserted while FULL -> out_valid=0 on the next cycle.
REQ-038 Counter (YMUX_XFER_CNT_EN defined): 5 output transfers -> xfer_cnt=5; counter preloaded to 16'hFFFF plus 1 transfer -> stays 16'hFFFF.
REQ-039 The exhaustive mux check loops over all data values for N=2 and W=2 and compares out_data against a model word by word.

Source files
------------

// File: rtl/ymux_rr_pkg.sv
// ymux_pkg: shared defaults, limits and output-register state encoding for ymux_rr
package ymux_pkg;
   localparam int W_DEF = 2;
   localparam int N_DEF = 4;
   localparam int N_MAX = 8;
   localparam int CNT_W = 16;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ostate_t;
endpackage

// File: rtl/ymux_rr_arb.sv
// ymux_rr_arb: combinational round-robin grant, searching from ptr+1 with wrap
module ymux_rr_arb
   import ymux_pkg::*;
#(
   parameter int N = N_DEF,
   localparam int CW = $clog2(N)
) (
   input  logic [N-1:0]  in_valid,
   input  logic [CW-1:0] ptr,
   output logic [N-1:0]  grant
);
   logic found;
   int   idx;
   // first valid channel after the last-served one wins, so every channel waits at most N-1 grants
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && in_valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/ymux_rr.sv
// ymux_rr: N-to-1 round-robin mux into a registered output slot; `YMUX_XFER_CNT_EN adds xfer_cnt
module ymux_rr
   import ymux_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int N = N_DEF,
   localparam int CW = $clog2(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [N*W-1:0] in_data,
   input  logic [N-1:0]   in_valid,
   output logic [N-1:0]   in_ready,
   output logic [W-1:0]   out_data,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [CW-1:0]  out_chan
`ifdef YMUX_XFER_CNT_EN
   ,output logic [CNT_W-1:0] xfer_cnt
`endif
);
   ostate_t       st;
   logic [CW-1:0] ptr;
   logic [CW-1:0] gidx;
   logic [N-1:0]  grant;
   logic [W-1:0]  gword;
   logic          can_load;
   logic          in_xfer;
   logic          out_xfer;

   ymux_rr_arb #(.N(N)) u_arb (
      .in_valid (in_valid),
      .ptr      (ptr),
      .grant    (grant)
   );

   assign out_valid = (st == FULL);
   assign can_load  = !out_valid | out_ready;
   assign in_ready  = reset ? '0 : grant & {N{can_load}};
   assign in_xfer   = |(in_valid & in_ready);
   assign out_xfer  = out_valid & out_ready;

   // encode the one-hot grant into a channel index and select its word
   always_comb begin
      gidx  = '0;
      gword = '0;
      for (int i = 0; i < N; i++)
         if (grant[i]) begin
            gidx  = CW'(i);
            gword = in_data[i*W +: W];
         end
   end

   // output slot: load on input transfer (also covers simultaneous drain), empty on drain alone
   always_ff @(posedge clk) begin
      if (reset) begin
         st       <= EMPTY;
         out_data <= '0;
         out_chan <= '0;
         ptr      <= CW'(N-1);
      end else if (in_xfer) begin
         st       <= FULL;
         out_data <= gword;
         out_chan <= gidx;
         ptr      <= gidx;
      end else if (out_xfer) begin
         st       <= EMPTY;
      end
   end

`ifdef YMUX_XFER_CNT_EN
   // saturating count of words taken by the consumer
   always_ff @(posedge clk) begin
      if (reset)
         xfer_cnt <= '0;
      else if (out_xfer && xfer_cnt != '1)
         xfer_cnt <= xfer_cnt + 1'b1;
   end
`endif
endmodule

// File: tb/tb_ymux_rr.sv
// tb_ymux_rr: directed self-checking bench for ymux_rr (N=4/W=2 plus an N=2/W=2 exhaustive instance)
module tb_ymux_rr;
   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic [3:0] in_valid;
   logic [3:0] in_ready;
   logic [1:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic [1:0] out_chan;
   logic       r2;
   logic [3:0] d2;
   logic [1:0] v2;
   logic [1:0] rdy2;
   logic [1:0] od2;
   logic       ov2;
   logic       oc2;
   int         n_cmp = 0;
   int         n_bad = 0;
`ifdef YMUX_XFER_CNT_EN
   logic [15:0] xfer_cnt;
   logic [15:0] xfer_cnt2;
`endif

   ymux_rr #(.W(2), .N(4)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan)
`ifdef YMUX_XFER_CNT_EN
      , .xfer_cnt(xfer_cnt)
`endif
   );

   ymux_rr #(.W(2), .N(2)) dut2 (
      .clk(clk), .reset(r2), .in_data(d2), .in_valid(v2), .in_ready(rdy2),
      .out_data(od2), .out_valid(ov2), .out_ready(1'b1), .out_chan(oc2)
`ifdef YMUX_XFER_CNT_EN
      , .xfer_cnt(xfer_cnt2)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int mptr;
      int g;
      logic [3:0] a;
      reset = 1'b1; in_valid = 4'b1111; in_data = 8'h00; out_ready = 1'b0;
      r2 = 1'b1; d2 = '0; v2 = '0;
      step(); step();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_chan", 32'(out_chan), 0);
      chk("rst_ptr", 32'(dut.ptr), 3);
      chk("rst_ready", 32'(in_ready), 0);
      // single channel
      reset = 1'b0; in_valid = 4'b0100; in_data = 8'h30; out_ready = 1'b1; #1;
      chk("one_ready", 32'(in_ready), 32'h4);
      step();
      chk("one_data", 32'(out_data), 3);
      chk("one_chan", 32'(out_chan), 2);
      chk("one_valid", 32'(out_valid), 1);
      chk("one_ptr", 32'(dut.ptr), 2);
      in_valid = 4'b0000; #1;
      chk("idle_ready", 32'(in_ready), 0);
      step();
      chk("drain_valid", 32'(out_valid), 0);
      chk("drain_hold", 32'(out_data), 3);
      chk("idle_ptr", 32'(dut.ptr), 2);
      // fairness from a fresh reset
      reset = 1'b1; step(); reset = 1'b0;
      in_valid = 4'b1111; in_data = 8'hE4; out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("fair_chan", 32'(out_chan), 32'(k % 4));
         chk("fair_data", 32'(out_data), 32'(k % 4));
         chk("fair_valid", 32'(out_valid), 1);
      end
      step();
      chk("bp_pre_chan", 32'(out_chan), 1);
      // backpressure with input data changing underneath
      out_ready = 1'b0; in_data = 8'h1B;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp_ready", 32'(in_ready), 0);
         step();
         chk("bp_chan", 32'(out_chan), 1);
         chk("bp_data", 32'(out_data), 1);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_ptr", 32'(dut.ptr), 1);
      end
      out_ready = 1'b1; #1;
      chk("bp_rel_ready", 32'(in_ready), 32'h4);
      step();
      chk("bp_rel_chan", 32'(out_chan), 2);
      chk("bp_rel_data", 32'(out_data), 1);
      // wrap: serve ch3 then only ch0
      in_valid = 4'b1000; step();
      chk("wrap_ptr3", 32'(dut.ptr), 3);
      in_valid = 4'b0001; #1;
      chk("wrap_ready", 32'(in_ready), 32'h1);
      step();
      chk("wrap_chan", 32'(out_chan), 0);
      chk("wrap_data", 32'(out_data), 3);
      chk("wrap_ptr0", 32'(dut.ptr), 0);
      // reset while FULL
      out_ready = 1'b0; in_valid = 4'b0000; reset = 1'b1; #1;
      chk("rst_mid_ready", 32'(in_ready), 0);
      step();
      chk("rst_mid_valid", 32'(out_valid), 0);
      chk("rst_mid_data", 32'(out_data), 0);
      chk("rst_mid_ptr", 32'(dut.ptr), 3);
      reset = 1'b0; in_valid = 4'b0010; #1;
      chk("post_rst_ready", 32'(in_ready), 32'h2);
      step();
      chk("post_rst_chan", 32'(out_chan), 1);
      chk("post_rst_data", 32'(out_data), 2);
      // exhaustive N=2 mux check against a small round-robin model
      step(); r2 = 1'b0; mptr = 1;
      for (int vp = 1; vp < 4; vp++)
         for (int x = 0; x < 16; x++) begin
            a = 4'(x); v2 = 2'(vp); d2 = a;
            g = v2[(mptr + 1) % 2] ? (mptr + 1) % 2 : mptr;
            step();
            chk("ex_data", 32'(od2), 32'(a[g*2 +: 2]));
            chk("ex_chan", 32'(oc2), 32'(g));
            mptr = g;
         end
`ifdef YMUX_XFER_CNT_EN
      reset = 1'b1; step(); reset = 1'b0;
      in_valid = 4'b1111; out_ready = 1'b1;
      step();
      for (int k = 0; k < 5; k++) step();
      chk("cnt_five", 32'(xfer_cnt), 5);
      for (int k = 5; k < 65535; k++) step();
      chk("cnt_max", 32'(xfer_cnt), 32'hFFFF);
      step();
      chk("cnt_sat", 32'(xfer_cnt), 32'hFFFF);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
